// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 width codes, FSM states, latched request.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    // RISC-V load/store funct3 encodings handled by the LSU
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        RESP
    } lsu_state_t;

    // Only the fields still needed after the handshake are kept: the byte
    // offset and width pick the load lane, write picks the ACCESS exit.
    typedef struct packed {
        logic [1:0] off;
        logic       write;
        logic [2:0] funct3;
    } lsu_req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated data, load extract and extend.
// Latency: combinational.
// Backpressure: none.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  data_en,
    output logic [31:0] lane_wdata,
    output logic [31:0] ext_rdata
);

    // Addressed byte/halfword moved down to bit 0
    logic [31:0] shifted;
    assign shifted = rdata >> {off, 3'b000};

    // Store lanes: replicate the datum so every lane the enable can pick holds it
    always_comb begin
        data_en    = 4'b0000;
        lane_wdata = wdata;
        case (funct3[1:0])
            2'd0: begin
                data_en    = 4'b0001 << off;
                lane_wdata = {4{wdata[7:0]}};
            end
            2'd1: begin
                data_en    = 4'b0011 << off;
                lane_wdata = {2{wdata[15:0]}};
            end
            2'd2: begin
                data_en    = 4'b1111;
                lane_wdata = wdata;
            end
            default: begin
                data_en    = 4'b0000;
                lane_wdata = wdata;
            end
        endcase
    end

    // Load extract: sign-extend for LB/LH, zero-extend for LBU/LHU
    always_comb begin
        ext_rdata = 32'd0;
        case (funct3)
            F3_B:    ext_rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ext_rdata = {24'd0, shifted[7:0]};
            F3_H:    ext_rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ext_rdata = {16'd0, shifted[15:0]};
            F3_W:    ext_rdata = rdata;
            default: ext_rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer onto one port of a byte-enabled BRAM.
// Latency: store resp 2 cycles, load resp 3 cycles, fault resp 1 cycle after handshake.
// Backpressure: req_ready only in IDLE; responses cannot be stalled.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 8192,
    localparam int AW      = $clog2(MEM_SIZE)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_fault,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [3:0]    mem_data_en,
    output logic          mem_write_en
);

    lsu_state_t  state;
    lsu_req_t    req_q;
    logic        we_q;
    logic        bad;
    logic [2:0]  lane_funct3;
    logic [1:0]  lane_off;
    logic [3:0]  lane_en;
    logic [31:0] lane_wdata;
    logic [31:0] ext_rdata;

    // Gating with reset_n keeps a reset landing mid-ACCESS from committing a write
    assign mem_write_en = we_q & reset_n;
    assign req_ready    = (state == IDLE) & reset_n;

    // Lane logic sees the live request at handshake and the latched one afterwards
    assign lane_funct3 = (state == IDLE) ? req_funct3    : req_q.funct3;
    assign lane_off    = (state == IDLE) ? req_addr[1:0] : req_q.off;

    lsu_lane_align u_lane_align (
        .funct3     (lane_funct3),
        .off        (lane_off),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .data_en    (lane_en),
        .lane_wdata (lane_wdata),
        .ext_rdata  (ext_rdata)
    );

    // Request legality: bad width code, wide store code, out of range, misaligned
    always_comb begin
        bad = 1'b0;
        if (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11)              bad = 1'b1;
        if (req_write && req_funct3 > F3_W)                              bad = 1'b1;
        if (req_addr >= 32'(MEM_SIZE))                                   bad = 1'b1;
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])  bad = 1'b1;
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)                bad = 1'b1;
    end

    // Sequencer FSM; all memory and response outputs are registered here
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_q       <= '0;
            we_q        <= 1'b0;
            mem_data_en <= 4'b0000;
            mem_addr    <= '0;
            mem_wdata   <= 32'd0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            resp_fault  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q <= '{off: req_addr[1:0], write: req_write, funct3: req_funct3};
                        if (bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state     <= ACCESS;
                            mem_addr  <= req_addr[AW-1:0];
                            mem_wdata <= lane_wdata;
                            if (req_write) begin
                                we_q        <= 1'b1;
                                mem_data_en <= lane_en;
                            end
                        end
                    end
                end
                ACCESS: begin
                    we_q        <= 1'b0;
                    mem_data_en <= 4'b0000;
                    if (req_q.write) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= 32'd0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // BRAM output now holds the word addressed during ACCESS
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= ext_rdata;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: BRAM model, byte-level reference memory, per-cycle scoreboard.
// Latency: n/a.
// Backpressure: driver waits on req_ready with a bounded loop.
module tb_load_store_unit;

    localparam int MEM_SIZE = 8192;
    localparam int AW       = 13;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [3:0]    mem_data_en;
    logic          mem_write_en;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_write    (req_write),
        .req_funct3   (req_funct3),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_data_en  (mem_data_en),
        .mem_write_en (mem_write_en)
    );

    // Backing BRAM: byte-enabled write, one-cycle registered read
    logic [31:0] bram [MEM_SIZE/4];
    always @(posedge clk) begin
        if (mem_write_en)
            for (int i = 0; i < 4; i++)
                if (mem_data_en[i]) bram[mem_addr[AW-1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        mem_rdata <= bram[mem_addr[AW-1:2]];
    end

    // Reference memory as a flat byte array
    logic [7:0] ref_mem [MEM_SIZE];

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    en;
        logic [31:0]   wd;
    } wexp_t;

    bit            exp_resp  [int];
    logic [31:0]   exp_rdata [int];
    bit            exp_fault [int];
    wexp_t         exp_wr    [int];
    logic [AW-1:0] exp_ld    [int];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          busy_end = -1;
    int          resp_count = 0;
    int          hs_q[$];
    logic [31:0] last_rdata;
    logic        last_fault;
    logic [3:0]  last_en;
    logic [31:0] last_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // What a request must do, from the ISA width rules applied to the byte array
    function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic w,
                                  input logic [2:0] f, output bit flt, output logic [3:0] en,
                                  output logic [31:0] wd, output logic [31:0] rd);
        int size;
        int off;
        size = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
        off  = int'(a % 4);
        flt  = (f == 3) || (f == 6) || (f == 7) || (w && f > 2) || (a >= MEM_SIZE) ||
               ((f == 1 || f == 5) && (a % 2 != 0)) || (f == 2 && (a % 4 != 0));
        en   = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % size) +: 8];
        rd = 32'd0;
        if (!flt && !w) begin
            for (int k = 0; k < size; k++) rd = rd | (32'(ref_mem[a + k]) << (8 * k));
            if (f < 4 && size < 4 && rd[8*size-1]) rd = rd | ~((32'h1 << (8 * size)) - 1);
        end
    endfunction

    // Compare process: every cycle, DUT outputs against the scheduled expectations
    initial begin
        bit          flt;
        logic [3:0]  en;
        logic [31:0] wd;
        logic [31:0] rd;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                chk("ready_in_reset", req_ready, 0);
                chk("we_in_reset", mem_write_en, 0);
                exp_resp.delete(); exp_rdata.delete(); exp_fault.delete();
                exp_wr.delete(); exp_ld.delete();
                busy_end = -1;
                continue;
            end
            if (exp_resp.exists(cyc)) begin
                chk("resp_valid", resp_valid, 1);
                chk("resp_rdata", resp_rdata, exp_rdata[cyc]);
                chk("resp_fault", resp_fault, 32'(exp_fault[cyc]));
                last_rdata = resp_rdata;
                last_fault = resp_fault;
                resp_count++;
                exp_resp.delete(cyc);
            end else begin
                chk("resp_valid_quiet", resp_valid, 0);
            end
            chk("req_ready", req_ready, 32'(cyc > busy_end));
            if (exp_wr.exists(cyc)) begin
                chk("mem_write_en", mem_write_en, 1);
                chk("mem_data_en", mem_data_en, exp_wr[cyc].en);
                chk("mem_wdata", mem_wdata, exp_wr[cyc].wd);
                chk("mem_addr_st", 32'(mem_addr), 32'(exp_wr[cyc].addr));
                last_en = mem_data_en;
                last_wd = mem_wdata;
                for (int i = 0; i < 4; i++)
                    if (exp_wr[cyc].en[i])
                        ref_mem[{exp_wr[cyc].addr[AW-1:2], 2'(i)}] = exp_wr[cyc].wd[8*i +: 8];
                exp_wr.delete(cyc);
            end else begin
                chk("mem_write_en_quiet", mem_write_en, 0);
                chk("mem_data_en_quiet", mem_data_en, 0);
            end
            if (exp_ld.exists(cyc)) begin
                chk("mem_addr_ld", 32'(mem_addr), 32'(exp_ld[cyc]));
                exp_ld.delete(cyc);
            end
            if (req_valid && req_ready) begin
                hs_q.push_back(cyc);
                model(req_addr, req_wdata, req_write, req_funct3, flt, en, wd, rd);
                busy_end = cyc + (flt ? 1 : (req_write ? 2 : 3));
                exp_resp[busy_end]  = 1'b1;
                exp_rdata[busy_end] = (flt || req_write) ? 32'd0 : rd;
                exp_fault[busy_end] = flt;
                if (!flt) begin
                    if (req_write) exp_wr[cyc + 1] = '{addr: req_addr[AW-1:0], en: en, wd: wd};
                    else           exp_ld[cyc + 1] = req_addr[AW-1:0];
                end
            end
        end
    end

    // Present a request and return just after the handshake edge
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] f);
        int n = 0;
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_write = w; req_funct3 = f;
        @(negedge clk);
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("handshake_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_resps(input int start, input int count);
        for (int i = 0; i < 40 && resp_count < start + count; i++) @(posedge clk);
        #1;
        if (resp_count < start + count) chk("resp_timeout", 32'(resp_count), 32'(start + count));
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [2:0] f);
        int s;
        s = resp_count;
        issue(a, d, w, f);
        req_valid = 1'b0;
        wait_resps(s, 1);
    endtask

    initial begin
        int s;
        for (int i = 0; i < MEM_SIZE / 4; i++) begin
            bram[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = bram[i][8*b +: 8];
        end
        reset_n = 1'b0; req_valid = 1'b0; req_addr = 0; req_wdata = 0; req_write = 0; req_funct3 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_data_en", mem_data_en, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Word store then load
        txn(32'h10, 32'hDEADBEEF, 1, 3'd2);
        chk("sw_en", last_en, 4'b1111);
        txn(32'h10, 32'h0, 0, 3'd2);
        chk("lw_10", last_rdata, 32'hDEADBEEF);
        chk("lw_10_fault", last_fault, 0);

        // Byte store at lane 3, signed and unsigned reload
        txn(32'h13, 32'h000000A5, 1, 3'd0);
        chk("sb_en", last_en, 4'b1000);
        chk("sb_wdata", last_wd, 32'hA5A5A5A5);
        txn(32'h13, 32'h0, 0, 3'd0);
        chk("lb_13", last_rdata, 32'hFFFFFFA5);
        txn(32'h13, 32'h0, 0, 3'd4);
        chk("lbu_13", last_rdata, 32'h000000A5);
        txn(32'h10, 32'h0, 0, 3'd2);
        chk("lw_10_after_sb", last_rdata, 32'hA5ADBEEF);

        // Halfword store at upper half
        txn(32'h12, 32'h00008001, 1, 3'd1);
        chk("sh_en", last_en, 4'b1100);
        chk("sh_wdata", last_wd, 32'h80018001);
        txn(32'h12, 32'h0, 0, 3'd1);
        chk("lh_12", last_rdata, 32'hFFFF8001);
        txn(32'h12, 32'h0, 0, 3'd5);
        chk("lhu_12", last_rdata, 32'h00008001);

        // Faulting requests: no memory activity, one-cycle response
        txn(32'h11, 32'h0, 0, 3'd1);
        chk("lh_odd_fault", last_fault, 1);
        chk("lh_odd_rdata", last_rdata, 0);
        txn(32'h22, 32'h11112222, 1, 3'd2);
        chk("sw_mis_fault", last_fault, 1);
        txn(32'h2000, 32'h0, 0, 3'd2);
        chk("lw_range_fault", last_fault, 1);
        txn(32'h10, 32'h55, 1, 3'd4);
        chk("sb_f3_4_fault", last_fault, 1);
        txn(32'h10, 32'h0, 0, 3'd2);
        chk("lw_10_unchanged", last_rdata, 32'h8001BEEF);

        // Reset during the ACCESS cycle of a store drops it
        txn(32'h40, 32'hCAFEF00D, 1, 3'd2);
        issue(32'h40, 32'h12345678, 1, 3'd2);
        req_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_mem_addr", 32'(mem_addr), 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        chk("midrst_data_en", mem_data_en, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);
        @(posedge clk); #1;
        txn(32'h40, 32'h0, 0, 3'd2);
        chk("lw_40_after_rst", last_rdata, 32'hCAFEF00D);

        // Back-to-back loads with req_valid held: accepted four cycles apart
        s = resp_count;
        issue(32'h10, 32'h0, 0, 3'd2);
        issue(32'h12, 32'h0, 0, 3'd1);
        issue(32'h40, 32'h0, 0, 3'd0);
        req_valid = 1'b0;
        wait_resps(s, 3);
        chk("b2b_gap1", 32'(hs_q[$-1] - hs_q[$-2]), 4);
        chk("b2b_gap2", 32'(hs_q[$] - hs_q[$-1]), 4);

        // Randomized mix, including illegal codes, misalignment and out-of-range
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 15))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(MEM_SIZE - 8, MEM_SIZE + 8));
                default: a = 32'h100 + 32'($urandom_range(0, 63));
            endcase
            issue(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
